// File: rtl/serial_word_assembler.sv
// serial_word_assembler
//   Front end for the n-bit enable register. Watches an idle-high serial line
//   for a start bit, then shifts in n data bits LSB-first. After the data bits
//   it checks the stop bit and presents the finished word, with a one-cycle
//   valid pulse that can drive the register's load enable directly.
//
//   Optional feature: define PARITY_EN to expect an even-parity bit between the
//   last data bit and the stop bit. A parity mismatch is reported as a frame
//   error. Without PARITY_EN, the parity state and logic are not built.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-low reset
//   sin         in   serial data; the line idles at 1
//   bit_en      in   bit-sample strobe; sin is only looked at when this is 1
//   word        out  [n-1:0] last correctly framed word, held between frames
//   word_valid  out  one-cycle pulse marking the cycle in which word changed
//   frame_err   out  stop/parity fault on the last frame; cleared by the next start
//   busy        out  high whenever a frame is in progress (FSM not idle)

module serial_word_assembler #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sin,
  input  logic         bit_en,
  output logic [n-1:0] word,
  output logic         word_valid,
  output logic         frame_err,
  output logic         busy
);

  // One extra counter bit so the count can reach n without wrapping.
  localparam int CW = $clog2(n) + 1;

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [n-1:0]  shift_q, shift_d;
  logic [n-1:0]  word_d;
  logic          valid_d;
  logic          err_d;
  logic          frame_ok;

`ifdef PARITY_EN
  logic par_q, par_d;

  // Even parity: the data bits plus the parity bit must hold an even count of ones.
  assign frame_ok = ~(^shift_q ^ par_q);
`else
  assign frame_ok = 1'b1;
`endif

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      word       <= word_d;
      word_valid <= valid_d;
      frame_err  <= err_d;
`ifdef PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // Everything holds unless bit_en is high. The one exception is word_valid:
  // it defaults to 0, so its pulse is always one clock wide, whatever the
  // strobe rate.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word;
    valid_d = 1'b0;
    err_d   = frame_err;
`ifdef PARITY_EN
    par_d   = par_q;
`endif

    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!sin) begin
            state_d = DATA;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end

        DATA: begin
          // Store the bit at the position given by the count (LSB first). The
          // compare loop avoids indexing with the wider counter.
          for (int i = 0; i < n; i++) begin
            if (cnt_q == CW'(i)) begin
              shift_d[i] = sin;
            end
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(n - 1)) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end

`ifdef PARITY_EN
        PARITY: begin
          par_d   = sin;
          state_d = STOP;
        end
`endif

        STOP: begin
          state_d = IDLE;
          if (sin && frame_ok) begin
            word_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule
